// File: rtl/fec_dec_seq.sv
// Sequential SECDED decoder for a 16-bit Hamming(15,11)+overall-parity word.
// It reads the codeword from the register file and writes back the message and status bytes.
module fec_dec_seq #(
  parameter int W      = 8,
  parameter int D      = 4,
  parameter int SRC_LO = 13,
  parameter int SRC_HI = 14,
  parameter int DST_LO = 11,
  parameter int DST_HI = 12
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  output logic [D-1:0] raddrA,
  output logic [D-1:0] raddrB,
  input  logic [W-1:0] rdataA,
  input  logic [W-1:0] rdataB,
  output logic         write_en,
  output logic [D-1:0] waddr,
  output logic [W-1:0] wdata,
  output logic         busy,
  output logic         done,
  output logic [1:0]   err_flag,
  output logic [7:0]   corr_cnt,
  output logic [7:0]   uncorr_cnt
);

  typedef enum logic [2:0] {
    IDLE, READ, SYND, CORR, WR_LO, WR_HI, DONE
  } state_t;

  state_t        r_state, w_next;
  logic [15:0]   r_cw;
  logic [3:0]    r_syn;
  logic          r_par;
  logic [10:0]   r_msg;
  logic [1:0]    r_flag;
  logic [D-1:0]  r_waddr;
  logic [W-1:0]  r_wdata;
  logic [1:0]    r_errFlag;
  logic [7:0]    r_corrCnt;
  logic [7:0]    r_uncorrCnt;

  logic [3:0]    w_syn;
  logic          w_par;
  logic [15:0]   w_fixed;
  logic [10:0]   w_msg;
  logic [1:0]    w_flag;

  assign raddrA     = D'(SRC_HI);
  assign raddrB     = D'(SRC_LO);
  assign waddr      = r_waddr;
  assign wdata      = r_wdata;
  assign err_flag   = r_errFlag;
  assign corr_cnt   = r_corrCnt;
  assign uncorr_cnt = r_uncorrCnt;

  always_comb begin
    w_syn = 4'd0;
    for (int i = 1; i < 16; i++) begin
      if (r_cw[i]) w_syn = w_syn ^ 4'(i);
    end
    w_par = ^r_cw;
  end

  // A nonzero syndrome only gets corrected when the overall parity confirms a single error.
  always_comb begin
    w_fixed = r_cw;
    w_flag  = 2'b00;
    if (r_syn != 4'd0 && r_par) begin
      w_fixed = r_cw ^ (16'd1 << r_syn);
      w_flag  = 2'b01;
    end else if (r_syn == 4'd0 && r_par) begin
      w_flag  = 2'b01;
    end else if (r_syn != 4'd0 && !r_par) begin
      w_flag  = 2'b10;
    end
    w_msg = {w_fixed[15:9], w_fixed[7:5], w_fixed[3]};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    write_en = 1'b0;
    done     = 1'b0;
    busy     = (r_state != IDLE);
    case (r_state)
      IDLE:  if (start) w_next = READ;
      READ:  w_next = SYND;
      SYND:  w_next = CORR;
      CORR:  w_next = WR_LO;
      WR_LO: begin write_en = 1'b1; w_next = WR_HI; end
      WR_HI: begin write_en = 1'b1; w_next = DONE; end
      DONE:  begin done = 1'b1; w_next = IDLE; end
      default: w_next = IDLE;
    endcase
  end

  // Status and counters are loaded on entry to DONE so they are valid alongside the done pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cw        <= '0;
      r_syn       <= '0;
      r_par       <= 1'b0;
      r_msg       <= '0;
      r_flag      <= '0;
      r_waddr     <= '0;
      r_wdata     <= '0;
      r_errFlag   <= '0;
      r_corrCnt   <= '0;
      r_uncorrCnt <= '0;
    end else begin
      case (r_state)
        READ: r_cw <= {rdataA, rdataB};
        SYND: begin
          r_syn <= w_syn;
          r_par <= w_par;
        end
        CORR: begin
          r_msg   <= w_msg;
          r_flag  <= w_flag;
          r_waddr <= D'(DST_LO);
          r_wdata <= w_msg[7:0];
        end
        WR_LO: begin
          r_waddr <= D'(DST_HI);
          r_wdata <= {r_flag, 3'b000, r_msg[10:8]};
        end
        WR_HI: begin
          r_errFlag <= r_flag;
          if (r_flag == 2'b01 && r_corrCnt != 8'hFF)
            r_corrCnt <= r_corrCnt + 8'd1;
          if (r_flag == 2'b10 && r_uncorrCnt != 8'hFF)
            r_uncorrCnt <= r_uncorrCnt + 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/fec_dec_seq.md
Name: fec_dec_seq

Overview:
- Sequential SECDED decoder that sits on the register file's ports and acts as its reader and writer.
- On `start`, it reads a 16-bit Hamming(15,11)+overall-parity codeword from two source registers. It then computes the syndrome, corrects a single error or flags a double error, and writes the 11-bit message plus status back into two destination registers through the register-file write port.
- It is the decode counterpart of the encoder path that fills the source registers.

Parameters:
- W, 8, register data width; the block requires W=8.
- D, 4, register address width.
- SRC_LO, 13, address of the codeword low byte.
- SRC_HI, 14, address of the codeword high byte.
- DST_LO, 11, address for message byte 0.
- DST_HI, 12, address for the {flag, message high bits} byte.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request decode; sampled only in IDLE.
- raddrA  out  D  register-file read address A; constant SRC_HI.
- raddrB  out  D  register-file read address B; constant SRC_LO.
- rdataA  in  W  register-file data_outA; combinational read.
- rdataB  in  W  register-file data_outB.
- write_en  out  1  register-file write enable.
- waddr  out  D  register-file write address.
- wdata  out  W  register-file write data.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse when the operation is complete.
- err_flag  out  2  00 = clean, 01 = corrected, 10 = uncorrectable; held until the next done.
- corr_cnt  out  8  saturating count of corrected words.
- uncorr_cnt  out  8  saturating count of uncorrectable words.

Behaviour:
- Reset (reset=0, asynchronous):
  - state returns to IDLE.
  - write_en, done, busy, waddr, wdata, err_flag, corr_cnt and uncorr_cnt all go to 0 immediately.
  - An operation interrupted by reset performs no further writes; a write already committed stays committed.
- Codeword layout: cw[15:0] = {rdataA, rdataB}.
  - cw[0] is the overall parity p0.
  - cw[1], cw[2], cw[4], cw[8] are the Hamming parity bits.
  - Data bits sit at positions 3,5,6,7,9,10,11,12,13,14,15, mapping to msg[0]..msg[10] in ascending order.
- Syndrome and parity:
  - s[3:0] = XOR of the indices i in 1..15 where cw[i]=1.
  - P = XOR of all 16 bits.
- Classification:
  - s=0, P=0: clean; flag 00.
  - s≠0, P=1: flip cw[s]; flag 01.
  - s=0, P=1: p0-only error, data untouched; flag 01.
  - s≠0, P=0: double error, no correction applied, message extracted raw; flag 10.
- Output bytes:
  - DST_LO receives msg[7:0].
  - DST_HI receives {flag[1:0], 3'b000, msg[10:8]}.
- FSM (registered state; outputs decoded from state and registers only):
  - IDLE: start=1 -> READ.
  - READ: latch cw from rdataA/rdataB -> SYND.
  - SYND: register s and P -> CORR.
  - CORR: register the corrected msg and flag -> WR_LO.
  - WR_LO: write_en=1, waddr=DST_LO, wdata=lo byte -> WR_HI.
  - WR_HI: write_en=1, waddr=DST_HI, wdata=hi byte -> DONE.
  - DONE: done=1; update err_flag; increment the matching counter (saturate at 255) -> IDLE.
- Latency: start sampled at edge N; writes commit at edges N+4 and N+5; done is high between edges N+5 and N+6.
- Back-to-back operation: the next start is accepted in IDLE at edge N+6 at the earliest.
- start while busy is ignored; it is not queued.
- write_en is 0 in every state except WR_LO and WR_HI. waddr and wdata hold their last value when write_en=0.
- Source registers are sampled only in READ. Changes to them after READ do not affect the result.

Test Plan:
- src {hi,lo}={00,00}, start -> reg11=0x00, reg12=0x00, err_flag=00, done at start+6 edges, counters unchanged.
- {00,0F} (valid codeword, msg=1) -> reg11=0x01, reg12=0x00, flag 00.
- {00,20} (single error at position 5) -> reg11=0x00, reg12=0x40, flag 01, corr_cnt=1; also {00,01} (p0 only) -> reg12=0x40, corr_cnt=2.
- {00,28} (errors at positions 3 and 5) -> reg11=0x03, reg12=0x80, flag 10, uncorr_cnt=1.
- Pulse start again during SYND -> ignored: exactly two write_en cycles and one done pulse. Separately, drive reset low during WR_HI -> write_en drops asynchronously, reg12 unchanged, counters return to 0, busy=0.
- 260 consecutive single-error words -> corr_cnt saturates at 255 and stays there.
